// File: rtl/alu_pkg.sv
// Types, constants and the CRC3 helper shared by the sin stimulus side and the sout receive side.
package alu_pkg;

  localparam int unsigned FRAME_BITS  = 11;
  localparam int unsigned DATA_FRAMES = 4;

  typedef enum logic {
    DATA = 1'b0,
    CTL  = 1'b1
  } frame_type_t;

  typedef enum logic [1:0] {
    ProtoNone      = 2'b00,
    ProtoStop      = 2'b01,
    ProtoEarlyCtl  = 2'b10,
    ProtoExtraData = 2'b11
  } proto_code_t;

  // Bit-serial CRC, polynomial x^3+x+1, init 0, message consumed MSB first.
  function automatic logic [2:0] crc3(input logic [36:0] data);
    logic [2:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ data[i];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

endpackage

// File: rtl/alu_frame_rx.sv
// Frame receiver: bit counter and shift register for one 11-bit sout frame after its start bit.
module alu_frame_rx
  import alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sout_i,
  input  logic        start_i,
  input  logic        shift_i,
  output logic        frame_valid_o,
  output frame_type_t frame_type_o,
  output logic [7:0]  payload_o,
  output logic        stop_ok_o
);

  localparam int unsigned CntW = $clog2(FRAME_BITS);
  localparam logic [CntW-1:0] LastBit = CntW'(FRAME_BITS - 2);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [8:0]      sr_q, sr_d;
  logic            last_bit;

  assign last_bit = (cnt_q == LastBit);

  // The stop bit is not shifted in so {type, payload} stays aligned in sr_q.
  always_comb begin
    cnt_d = cnt_q;
    sr_d  = sr_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      if (last_bit) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sr_d  = {sr_q[7:0], sout_i};
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

  assign frame_valid_o = shift_i & last_bit;
  assign frame_type_o  = frame_type_t'(sr_q[8]);
  assign payload_o     = sr_q[7:0];
  assign stop_ok_o     = sout_i;

endmodule

// File: rtl/alu_sout_deser.sv
// sout deserializer: frame FSM, byte assembly and result/error/protocol checks with registered outputs.
module alu_sout_deser
  import alu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sout_i,
  output logic        res_valid_o,
  output logic [31:0] res_c_o,
  output logic [3:0]  res_flags_o,
  output logic        res_crc_ok_o,
  output logic        err_valid_o,
  output logic [5:0]  err_flags_o,
  output logic        err_parity_ok_o,
  output logic        err_dup_ok_o,
  output logic        proto_err_o,
  output logic [1:0]  proto_code_o
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDecode
  } state_e;

  localparam int unsigned BcntW = $clog2(DATA_FRAMES + 1);
  localparam int unsigned IdxW  = $clog2(DATA_FRAMES);
  localparam logic [BcntW-1:0] FullCnt = BcntW'(DATA_FRAMES);

  state_e state_q, state_d;
  logic   rx_start, rx_shift;

  logic        frame_valid;
  frame_type_t frame_type;
  logic [7:0]  payload;
  logic        stop_ok;

  logic [BcntW-1:0]              bcnt_q, bcnt_d;
  logic [0:DATA_FRAMES-1][7:0]   shadow_q, shadow_d;
  logic [2:0]                    crc_calc;

  logic        res_valid_q, res_valid_d;
  logic [31:0] res_c_q, res_c_d;
  logic [3:0]  res_flags_q, res_flags_d;
  logic        res_crc_ok_q, res_crc_ok_d;
  logic        err_valid_q, err_valid_d;
  logic [5:0]  err_flags_q, err_flags_d;
  logic        err_parity_ok_q, err_parity_ok_d;
  logic        err_dup_ok_q, err_dup_ok_d;
  logic        proto_err_q, proto_err_d;
  proto_code_t proto_code_q, proto_code_d;

  alu_frame_rx u_frame_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .sout_i       (sout_i),
    .start_i      (rx_start),
    .shift_i      (rx_shift),
    .frame_valid_o(frame_valid),
    .frame_type_o (frame_type),
    .payload_o    (payload),
    .stop_ok_o    (stop_ok)
  );

  // A low line in StDecode is ignored; the next start bit must arrive in StIdle.
  always_comb begin
    state_d  = state_q;
    rx_start = 1'b0;
    rx_shift = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!sout_i) begin
          rx_start = 1'b1;
          state_d  = StShift;
        end
      end
      StShift: begin
        rx_shift = 1'b1;
        if (frame_valid) state_d = StDecode;
      end
      StDecode: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Byte 0 of the shadow lands in C[31:24].
  assign crc_calc = crc3({shadow_q, 1'b0, payload[6:3]});

  // Decision is taken on the stop-bit edge so the pulses fill the StDecode cycle.
  always_comb begin
    bcnt_d          = bcnt_q;
    shadow_d        = shadow_q;
    res_valid_d     = 1'b0;
    res_c_d         = res_c_q;
    res_flags_d     = res_flags_q;
    res_crc_ok_d    = res_crc_ok_q;
    err_valid_d     = 1'b0;
    err_flags_d     = err_flags_q;
    err_parity_ok_d = err_parity_ok_q;
    err_dup_ok_d    = err_dup_ok_q;
    proto_err_d     = 1'b0;
    proto_code_d    = proto_code_q;
    if (frame_valid) begin
      if (!stop_ok) begin
        proto_err_d  = 1'b1;
        proto_code_d = ProtoStop;
        bcnt_d       = '0;
      end else if (frame_type == DATA) begin
        if (bcnt_q == FullCnt) begin
          proto_err_d  = 1'b1;
          proto_code_d = ProtoExtraData;
          bcnt_d       = '0;
        end else begin
          shadow_d[bcnt_q[IdxW-1:0]] = payload;
          bcnt_d                     = bcnt_q + 1'b1;
        end
      end else if (payload[7]) begin
        err_valid_d     = 1'b1;
        err_flags_d     = payload[6:1];
        err_parity_ok_d = (payload[0] == ^{1'b1, payload[6:1]});
        err_dup_ok_d    = (payload[6:4] == payload[3:1]);
        bcnt_d          = '0;
      end else if (bcnt_q == FullCnt) begin
        res_valid_d  = 1'b1;
        res_c_d      = shadow_q;
        res_flags_d  = payload[6:3];
        res_crc_ok_d = (payload[2:0] == crc_calc);
        bcnt_d       = '0;
      end else begin
        proto_err_d  = 1'b1;
        proto_code_d = ProtoEarlyCtl;
        bcnt_d       = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      bcnt_q          <= '0;
      shadow_q        <= '0;
      res_valid_q     <= 1'b0;
      res_c_q         <= '0;
      res_flags_q     <= '0;
      res_crc_ok_q    <= 1'b0;
      err_valid_q     <= 1'b0;
      err_flags_q     <= '0;
      err_parity_ok_q <= 1'b0;
      err_dup_ok_q    <= 1'b0;
      proto_err_q     <= 1'b0;
      proto_code_q    <= ProtoNone;
    end else begin
      state_q         <= state_d;
      bcnt_q          <= bcnt_d;
      shadow_q        <= shadow_d;
      res_valid_q     <= res_valid_d;
      res_c_q         <= res_c_d;
      res_flags_q     <= res_flags_d;
      res_crc_ok_q    <= res_crc_ok_d;
      err_valid_q     <= err_valid_d;
      err_flags_q     <= err_flags_d;
      err_parity_ok_q <= err_parity_ok_d;
      err_dup_ok_q    <= err_dup_ok_d;
      proto_err_q     <= proto_err_d;
      proto_code_q    <= proto_code_d;
    end
  end

  assign res_valid_o     = res_valid_q;
  assign res_c_o         = res_c_q;
  assign res_flags_o     = res_flags_q;
  assign res_crc_ok_o    = res_crc_ok_q;
  assign err_valid_o     = err_valid_q;
  assign err_flags_o     = err_flags_q;
  assign err_parity_ok_o = err_parity_ok_q;
  assign err_dup_ok_o    = err_dup_ok_q;
  assign proto_err_o     = proto_err_q;
  assign proto_code_o    = proto_code_q;

endmodule
